// File: rtl/burst_req_arbiter_pkg.sv
// burst_req_arbiter_pkg: shared width derivations and descriptor slice helpers
package burst_req_arbiter_pkg;
  function automatic int port_idx_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int desc_width(int len_w, int addr_w);
    return len_w + addr_w;
  endfunction
  function automatic int desc_lsb(int port, int len_w, int addr_w);
    return port * desc_width(len_w, addr_w);
  endfunction
  function automatic int desc_len_lsb(int addr_w);
    return addr_w;
  endfunction
endpackage

// File: rtl/burst_req_arbiter_if.sv
// burst_req_arbiter_if: descriptor, AR, R-completion and order-FIFO signals of the arbiter
interface burst_req_arbiter_if import burst_req_arbiter_pkg::*; #(
  parameter int NumPorts = 2,
  parameter int AddrWidth = 64,
  parameter int BurstLenWidth = 8,
  parameter int MaxOutstanding = 16,
  parameter int PortIdxWidth = port_idx_width(NumPorts),
  parameter int CntWidth = $clog2(MaxOutstanding + 1)
);
  logic [NumPorts*desc_width(BurstLenWidth, AddrWidth)-1:0] req_dout;
  logic [NumPorts-1:0] req_empty_n;
  logic [NumPorts-1:0] req_read;
  logic [AddrWidth-1:0] m_axi_araddr;
  logic [BurstLenWidth-1:0] m_axi_arlen;
  logic m_axi_arvalid;
  logic m_axi_arready;
  logic r_last_fire;
  logic [PortIdxWidth-1:0] order_din;
  logic order_full_n;
  logic order_write;
  logic [CntWidth-1:0] outstanding;
  modport master (
    input req_dout, req_empty_n, m_axi_arready, r_last_fire, order_full_n,
    output req_read, m_axi_araddr, m_axi_arlen, m_axi_arvalid, order_din, order_write, outstanding
  );
  modport slave (
    output req_dout, req_empty_n, m_axi_arready, r_last_fire, order_full_n,
    input req_read, m_axi_araddr, m_axi_arlen, m_axi_arvalid, order_din, order_write, outstanding
  );
endinterface

// File: rtl/burst_req_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching cyclically from last+1
module rr_arbiter import burst_req_arbiter_pkg::*; #(
  parameter int N = 2,
  localparam int IW = port_idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic          enable,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          valid
);
  logic [N-1:0] rot;
  logic [IW-1:0] off;
  logic [IW:0] sum;
  always_comb begin
    rot = N'({req, req} >> ({1'b0, last} + (IW+1)'(1)));
    off = '0;
    for (int i = N - 1; i >= 0; i--) off = rot[i] ? IW'(i) : off;
    sum = {1'b0, last} + {1'b0, off} + (IW+1)'(1);
    valid = enable && |req;
    grant_idx = !valid ? '0 : (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : sum[IW-1:0];
    grant = valid ? N'(1) << grant_idx : '0;
  end
endmodule

// File: rtl/burst_req_arbiter.sv
// burst_req_arbiter: round-robin AR channel sharing with outstanding-burst credit and grant-order log
module burst_req_arbiter import burst_req_arbiter_pkg::*; #(
  parameter int NumPorts = 2,
  parameter int AddrWidth = 64,
  parameter int BurstLenWidth = 8,
  parameter int MaxOutstanding = 16,
  parameter int PortIdxWidth = port_idx_width(NumPorts),
  parameter int CntWidth = $clog2(MaxOutstanding + 1)
) (
  input logic clk,
  input logic rst,
  burst_req_arbiter_if.master bus
);
  localparam int DescWidth = desc_width(BurstLenWidth, AddrWidth);
  logic [DescWidth-1:0] desc [NumPorts];
  logic [DescWidth-1:0] desc_sel;
  logic [PortIdxWidth-1:0] last_grant, grant_idx;
  logic [NumPorts-1:0] grant;
  logic [CntWidth-1:0] cnt;
  logic [AddrWidth-1:0] araddr;
  logic [BurstLenWidth-1:0] arlen;
  logic arvalid, grant_valid, can_issue;
  for (genvar g = 0; g < NumPorts; g++) begin : g_desc
    assign desc[g] = bus.req_dout[desc_lsb(g, BurstLenWidth, AddrWidth) +: DescWidth];
  end
  assign desc_sel = desc[grant_idx];
  // A completing burst frees its credit in the same cycle, so a full counter can still issue.
  assign can_issue = !rst && (!arvalid || bus.m_axi_arready) && bus.order_full_n &&
                     (cnt < CntWidth'(MaxOutstanding) || bus.r_last_fire);
  rr_arbiter #(.N(NumPorts)) u_rr (
    .req(bus.req_empty_n),
    .enable(can_issue),
    .last(last_grant),
    .grant(grant),
    .grant_idx(grant_idx),
    .valid(grant_valid)
  );
  assign bus.req_read = grant;
  assign bus.order_write = grant_valid;
  assign bus.order_din = grant_idx;
  assign bus.m_axi_araddr = araddr;
  assign bus.m_axi_arlen = arlen;
  assign bus.m_axi_arvalid = arvalid;
  assign bus.outstanding = cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      arvalid <= 1'b0;
      araddr <= '0;
      arlen <= '0;
      cnt <= '0;
      last_grant <= PortIdxWidth'(NumPorts - 1);
    end else begin
      if (grant_valid) begin
        arvalid <= 1'b1;
        araddr <= desc_sel[AddrWidth-1:0];
        arlen <= desc_sel[desc_len_lsb(AddrWidth) +: BurstLenWidth];
        last_grant <= grant_idx;
      end else if (bus.m_axi_arready) begin
        arvalid <= 1'b0;
      end
      if (grant_valid && !bus.r_last_fire) cnt <= cnt + CntWidth'(1);
      else if (!grant_valid && bus.r_last_fire && cnt != '0) cnt <= cnt - CntWidth'(1);
    end
  end
endmodule

// File: tb/tb_burst_req_arbiter.sv
// tb_burst_req_arbiter: directed and random stimulus against a queue-based reference model
module tb_burst_req_arbiter;
  localparam int NP = 2;
  localparam int AW = 64;
  localparam int BW = 8;
  localparam int MO = 3;
  localparam int DW = AW + BW;
  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] len;
  } ar_t;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int m_last;
  int m_out;
  ar_t pend[$];
  logic [AW-1:0] in_addr [NP];
  logic [BW-1:0] in_len [NP];
  burst_req_arbiter_if #(.NumPorts(NP), .AddrWidth(AW), .BurstLenWidth(BW), .MaxOutstanding(MO)) bus ();
  burst_req_arbiter #(.NumPorts(NP), .AddrWidth(AW), .BurstLenWidth(BW), .MaxOutstanding(MO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_desc(input int i, input logic [BW-1:0] len, input logic [AW-1:0] addr);
    in_len[i] = len;
    in_addr[i] = addr;
    bus.req_dout[i*DW +: DW] = {len, addr};
  endtask
  task automatic rand_descs();
    for (int i = 0; i < NP; i++) set_desc(i, BW'($urandom), {$urandom, $urandom});
  endtask
  task automatic step(input logic [NP-1:0] ne, input bit ard, input bit ofn, input bit rlf);
    int g;
    bit ok;
    bus.req_empty_n = ne;
    bus.m_axi_arready = ard;
    bus.order_full_n = ofn;
    bus.r_last_fire = rlf;
    #1;
    ok = (pend.size() == 0 || ard) && ofn && (m_out < MO || rlf);
    g = -1;
    if (ok)
      for (int k = 1; k <= NP; k++)
        if (g < 0 && ne[(m_last + k) % NP]) g = (m_last + k) % NP;
    check("req_read", bus.req_read, g < 0 ? 0 : 1 << g);
    check("order_write", bus.order_write, g >= 0);
    check("order_din", bus.order_din, g < 0 ? 0 : g);
    check("arvalid", bus.m_axi_arvalid, pend.size() != 0);
    if (pend.size() != 0) begin
      check("araddr", bus.m_axi_araddr, pend[0].addr);
      check("arlen", bus.m_axi_arlen, pend[0].len);
    end
    check("outstanding", bus.outstanding, m_out);
    @(posedge clk);
    if (pend.size() != 0 && ard) void'(pend.pop_front());
    if (g >= 0) begin
      pend.push_back('{in_addr[g], in_len[g]});
      m_last = g;
    end
    if (g >= 0 && !rlf) m_out++;
    else if (g < 0 && rlf && m_out > 0) m_out--;
    @(negedge clk);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.req_empty_n = '1;
    bus.m_axi_arready = 1'b1;
    bus.order_full_n = 1'b1;
    bus.r_last_fire = 1'b0;
    #1;
    check("rst_req_read", bus.req_read, 0);
    check("rst_order_write", bus.order_write, 0);
    check("rst_order_din", bus.order_din, 0);
    @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", bus.m_axi_arvalid, 0);
    check("rst_araddr", bus.m_axi_araddr, 0);
    check("rst_arlen", bus.m_axi_arlen, 0);
    check("rst_outstanding", bus.outstanding, 0);
    rst = 1'b0;
    pend.delete();
    m_last = NP - 1;
    m_out = 0;
  endtask
  initial begin
    rst = 1'b1;
    bus.req_dout = '0;
    rand_descs();
    @(negedge clk);
    do_reset();
    set_desc(0, 8'd3, 64'h1000);
    set_desc(1, 8'd0, 64'h2000);
    step(2'b11, 1, 1, 0);
    step(2'b11, 1, 1, 0);
    step(2'b00, 1, 1, 0);
    rand_descs();
    repeat (3) step(2'b11, 1, 1, 0);
    step(2'b11, 1, 1, 1);
    repeat (4) step(2'b00, 1, 1, 1);
    rand_descs();
    step(2'b11, 1, 1, 0);
    repeat (5) step(2'b11, 0, 1, 0);
    rand_descs();
    step(2'b11, 1, 1, 0);
    repeat (3) step(2'b11, 1, 0, 0);
    repeat (4) step(2'b00, 1, 1, 1);
    for (int n = 0; n < 2000; n++) begin
      rand_descs();
      step(NP'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           m_out > 0 ? $urandom_range(0, 2) == 0 : $urandom_range(0, 15) == 0);
    end
    repeat (5) step(2'b00, 1, 1, 1);
    rand_descs();
    repeat (3) step(2'b11, 1, 1, 0);
    check("pre_rst_outstanding", bus.outstanding, 3);
    check("pre_rst_arvalid", bus.m_axi_arvalid, 1);
    do_reset();
    bus.req_empty_n = '1;
    #1;
    check("post_rst_port0", bus.req_read, 1);
    rand_descs();
    repeat (4) step(2'b11, 1, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
